// File: rtl/sample_packer.sv
//------------------------------------------------------------------------------
// Module      : sample_packer
// Description : Capture front end for the SDRAM fill path. Waits for a masked
//               trigger, packs post-trigger samples into FIFO-width words and
//               pushes a fixed number of words into the fill FIFO.
//               Ports:
//                 wr_clk, rst        - clock, synchronous active-high reset
//                 sample_valid/data  - incoming channel samples
//                 arm, abort         - control pulses
//                 trig_mask/value    - masked trigger compare
//                 capture_words      - words per capture (0 means 1)
//                 wr_data_en/wr_data - FIFO write strobe and packed word
//                 wr_full            - FIFO full
//                 busy, triggered, done, overflow, words_written - status
// Revision    : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module sample_packer #(
    parameter int SAMPLE_WIDTH = 32,
    parameter int WORD_WIDTH   = 256,
    parameter int COUNT_WIDTH  = 27
) (
    input  logic                    wr_clk,
    input  logic                    rst,
    input  logic                    sample_valid,
    input  logic [SAMPLE_WIDTH-1:0] sample_data,
    input  logic                    arm,
    input  logic                    abort,
    input  logic [SAMPLE_WIDTH-1:0] trig_mask,
    input  logic [SAMPLE_WIDTH-1:0] trig_value,
    input  logic [COUNT_WIDTH-1:0]  capture_words,
    output logic                    wr_data_en,
    output logic [WORD_WIDTH-1:0]   wr_data,
    input  logic                    wr_full,
    output logic                    busy,
    output logic                    triggered,
    output logic                    done,
    output logic                    overflow,
    output logic [COUNT_WIDTH-1:0]  words_written
);

    localparam int c_LANES  = WORD_WIDTH / SAMPLE_WIDTH;
    localparam int c_LANE_W = (c_LANES > 1) ? $clog2(c_LANES) : 1;
    localparam logic [c_LANE_W-1:0] c_LAST_LANE = c_LANE_W'(c_LANES - 1);

    localparam logic [1:0] c_ST_IDLE    = 2'd0;
    localparam logic [1:0] c_ST_ARMED   = 2'd1;
    localparam logic [1:0] c_ST_CAPTURE = 2'd2;
    localparam logic [1:0] c_ST_DONE    = 2'd3;

    logic [1:0]              r_state;
    logic [c_LANE_W-1:0]     r_lane_cnt;
    logic [WORD_WIDTH-1:0]   r_word_buf;
    logic [COUNT_WIDTH-1:0]  r_len;
    logic [COUNT_WIDTH-1:0]  r_word_cnt;
    logic                    r_wr_data_en;
    logic [WORD_WIDTH-1:0]   r_wr_data;
    logic                    r_overflow;
    logic [COUNT_WIDTH-1:0]  r_words_written;

    logic                    w_trig_hit;
    logic                    w_accept;
    logic                    w_word_done;
    logic                    w_last_word;
    logic [WORD_WIDTH-1:0]   w_next_word;

    assign w_trig_hit  = sample_valid && (((sample_data ^ trig_value) & trig_mask) == '0);
    // The triggering sample itself is stored as lane 0 of the first word.
    assign w_accept    = (r_state == c_ST_CAPTURE && sample_valid) ||
                         (r_state == c_ST_ARMED && w_trig_hit);
    assign w_word_done = w_accept && (r_lane_cnt == c_LAST_LANE);
    assign w_last_word = (r_word_cnt + COUNT_WIDTH'(1)) == r_len;

    // Current buffer with the incoming sample dropped into the active lane.
    generate
        for (genvar l = 0; l < c_LANES; l++) begin : g_lane
            assign w_next_word[l*SAMPLE_WIDTH +: SAMPLE_WIDTH] =
                (r_lane_cnt == c_LANE_W'(l)) ? sample_data
                                             : r_word_buf[l*SAMPLE_WIDTH +: SAMPLE_WIDTH];
        end
    endgenerate

    always_ff @(posedge wr_clk) begin
        if (rst) begin
            r_state         <= c_ST_IDLE;
            r_lane_cnt      <= '0;
            r_word_buf      <= '0;
            r_len           <= '0;
            r_word_cnt      <= '0;
            r_wr_data_en    <= 1'b0;
            r_wr_data       <= '0;
            r_overflow      <= 1'b0;
            r_words_written <= '0;
        end else begin
            r_wr_data_en <= 1'b0;
            if (abort) begin
                // Partial word is discarded; nothing reaches the FIFO.
                r_state         <= c_ST_IDLE;
                r_lane_cnt      <= '0;
                r_word_cnt      <= '0;
                r_overflow      <= 1'b0;
                r_words_written <= '0;
            end else if (arm && (r_state == c_ST_IDLE || r_state == c_ST_DONE)) begin
                r_state         <= c_ST_ARMED;
                r_lane_cnt      <= '0;
                r_word_cnt      <= '0;
                r_overflow      <= 1'b0;
                r_words_written <= '0;
                r_len           <= (capture_words == '0) ? COUNT_WIDTH'(1) : capture_words;
            end else if (w_accept) begin
                if (r_state == c_ST_ARMED) begin
                    r_state <= c_ST_CAPTURE;
                end
                r_word_buf <= w_next_word;
                r_lane_cnt <= (r_lane_cnt == c_LAST_LANE) ? '0 : r_lane_cnt + c_LANE_W'(1);
                if (w_word_done) begin
                    if (!wr_full) begin
                        r_wr_data_en    <= 1'b1;
                        r_wr_data       <= w_next_word;
                        r_words_written <= r_words_written + COUNT_WIDTH'(1);
                    end else begin
                        r_overflow <= 1'b1;
                    end
                    // Dropped words still count so capture length stays time-aligned.
                    r_word_cnt <= r_word_cnt + COUNT_WIDTH'(1);
                    if (w_last_word) begin
                        r_state <= c_ST_DONE;
                    end
                end
            end
        end
    end

    assign wr_data_en    = r_wr_data_en;
    assign wr_data       = r_wr_data;
    assign overflow      = r_overflow;
    assign words_written = r_words_written;
    assign busy          = (r_state == c_ST_ARMED) || (r_state == c_ST_CAPTURE);
    assign triggered     = (r_state == c_ST_CAPTURE);
    assign done          = (r_state == c_ST_DONE);

endmodule

`default_nettype wire

// File: tb/tb_sample_packer.sv
//------------------------------------------------------------------------------
// Module      : tb_sample_packer
// Description : Scoreboard testbench for sample_packer. Expected FIFO words
//               are queued as stimulus is issued; a monitor pops and compares
//               on every write strobe. Status outputs are checked directly.
// Revision    : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module tb_sample_packer;

    logic         wr_clk;
    logic         rst;
    logic         sample_valid;
    logic [31:0]  sample_data;
    logic         arm;
    logic         abort;
    logic [31:0]  trig_mask;
    logic [31:0]  trig_value;
    logic [26:0]  capture_words;
    logic         wr_data_en;
    logic [255:0] wr_data;
    logic         wr_full;
    logic         busy;
    logic         triggered;
    logic         done;
    logic         overflow;
    logic [26:0]  words_written;

    int n_tests;
    int n_fail;
    logic [255:0] exp_q[$];

    sample_packer dut (
        .wr_clk        (wr_clk),
        .rst           (rst),
        .sample_valid  (sample_valid),
        .sample_data   (sample_data),
        .arm           (arm),
        .abort         (abort),
        .trig_mask     (trig_mask),
        .trig_value    (trig_value),
        .capture_words (capture_words),
        .wr_data_en    (wr_data_en),
        .wr_data       (wr_data),
        .wr_full       (wr_full),
        .busy          (busy),
        .triggered     (triggered),
        .done          (done),
        .overflow      (overflow),
        .words_written (words_written)
    );

    initial wr_clk = 1'b0;
    always #5 wr_clk = ~wr_clk;

    task automatic check(input string name, input logic [255:0] act, input logic [255:0] expv);
        n_tests++;
        if (act !== expv) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, expv);
        end
    endtask

    function automatic logic [255:0] seq_word(input logic [31:0] base);
        logic [255:0] w;
        w = '0;
        for (int k = 0; k < 8; k++) w[k*32 +: 32] = base + 32'(k);
        return w;
    endfunction

    // Monitor: every strobe must match the head of the scoreboard.
    always @(negedge wr_clk) begin
        if (!rst && wr_data_en) begin
            n_tests++;
            if (exp_q.size() == 0) begin
                n_fail++;
                $display("FAIL unexpected_strobe: got word %0h expected no strobe", wr_data);
            end else begin
                logic [255:0] e;
                e = exp_q.pop_front();
                if (wr_data !== e) begin
                    n_fail++;
                    $display("FAIL word_data: got %0h expected %0h", wr_data, e);
                end
            end
        end
    end

    task automatic step();
        @(posedge wr_clk);
        #1;
    endtask

    task automatic drive(input logic v, input logic [31:0] d);
        sample_valid = v;
        sample_data  = d;
        step();
        sample_valid = 1'b0;
    endtask

    task automatic do_arm(input logic [31:0] m, input logic [31:0] val, input logic [26:0] cw);
        trig_mask     = m;
        trig_value    = val;
        capture_words = cw;
        arm = 1'b1;
        step();
        arm = 1'b0;
    endtask

    task automatic wait_done(input string name);
        int n;
        n = 0;
        while (!done && n < 50) begin
            step();
            n++;
        end
        check(name, {255'd0, done}, 256'd1);
    endtask

    task automatic check_q_empty(input string name);
        step();
        step();
        check(name, 256'(exp_q.size()), 256'd0);
    endtask

    initial begin
        n_tests = 0;
        n_fail  = 0;
        rst = 1'b1; sample_valid = 1'b0; sample_data = '0; arm = 1'b0; abort = 1'b0;
        trig_mask = '0; trig_value = '0; capture_words = '0; wr_full = 1'b0;
        repeat (3) step();
        rst = 1'b0;

        // Reset state
        check("rst_outputs", {wr_data_en, busy, triggered, done, overflow}, 256'd0);
        check("rst_wr_data", wr_data, 256'd0);
        check("rst_words_written", 256'(words_written), 256'd0);

        // 1: mask 0, two words of sequential samples
        do_arm(32'h0, 32'h0, 27'd2);
        check("t1_busy", {255'd0, busy}, 256'd1);
        exp_q.push_back(seq_word(32'd0));
        exp_q.push_back(seq_word(32'd8));
        for (int i = 0; i < 16; i++) drive(1'b1, 32'(i));
        wait_done("t1_done");
        check("t1_words_written", 256'(words_written), 256'd2);
        check("t1_overflow", {255'd0, overflow}, 256'd0);
        check_q_empty("t1_queue_drained");

        // 2: masked trigger, pre-trigger samples dropped
        do_arm(32'hFF, 32'h5A, 27'd1);
        exp_q.push_back({32'h17, 32'h16, 32'h15, 32'h14, 32'h13, 32'h12, 32'h11, 32'h5A});
        drive(1'b1, 32'h10);
        check("t2_not_triggered", {255'd0, triggered}, 256'd0);
        drive(1'b1, 32'hABCD_005A);
        check("t2_triggered", {255'd0, triggered}, 256'd1);
        exp_q[0][31:0] = 32'hABCD_005A; // upper bits are outside the mask
        for (int i = 1; i < 8; i++) drive(1'b1, 32'h10 + 32'(i));
        wait_done("t2_done");
        check_q_empty("t2_queue_drained");

        // 3: FIFO full as word 1 of 3 completes
        do_arm(32'h0, 32'h0, 27'd3);
        exp_q.push_back(seq_word(32'h100));
        exp_q.push_back(seq_word(32'h110));
        for (int i = 0; i < 24; i++) begin
            wr_full = (i == 15);
            drive(1'b1, (i < 8) ? 32'h100 + 32'(i) : (i < 16) ? 32'h200 : 32'h110 + 32'(i - 16));
            wr_full = 1'b0;
        end
        wait_done("t3_done");
        check("t3_overflow", {255'd0, overflow}, 256'd1);
        check("t3_words_written", 256'(words_written), 256'd2);
        check_q_empty("t3_queue_drained");

        // 4: valid gaps, capture_words=0 behaves as 1
        do_arm(32'h0, 32'h0, 27'd0);
        exp_q.push_back(seq_word(32'h300));
        for (int i = 0; i < 8; i++) begin
            drive(1'b1, 32'h300 + 32'(i));
            if (i == 7) check("t4_strobe_timing", {255'd0, wr_data_en}, 256'd1);
            else        check("t4_no_early_strobe", {255'd0, wr_data_en}, 256'd0);
            drive(1'b0, 32'hDEAD);
            drive(1'b0, 32'hBEEF);
        end
        check("t4_done", {255'd0, done}, 256'd1);
        check("t4_words_written", 256'(words_written), 256'd1);
        check_q_empty("t4_queue_drained");

        // 5: abort mid-capture, then clean re-arm
        do_arm(32'h0, 32'h0, 27'd1);
        for (int i = 0; i < 5; i++) drive(1'b1, 32'h400 + 32'(i));
        abort = 1'b1;
        step();
        abort = 1'b0;
        check("t5_abort_idle", {busy, triggered, done, wr_data_en}, 256'd0);
        for (int i = 0; i < 4; i++) drive(1'b1, 32'h999);
        do_arm(32'h0, 32'h0, 27'd1);
        exp_q.push_back(seq_word(32'h500));
        for (int i = 0; i < 8; i++) drive(1'b1, 32'h500 + 32'(i));
        wait_done("t5_rearm_done");
        check("t5_words_written", 256'(words_written), 256'd1);
        check_q_empty("t5_queue_drained");

        // 6: arm+abort together from IDLE, then reset during capture
        abort = 1'b1;
        step();
        abort = 1'b0;
        arm = 1'b1; abort = 1'b1;
        step();
        arm = 1'b0; abort = 1'b0;
        check("t6_arm_abort_idle", {busy, triggered, done}, 256'd0);
        do_arm(32'h0, 32'h0, 27'd1);
        for (int i = 0; i < 7; i++) drive(1'b1, 32'h600 + 32'(i));
        sample_valid = 1'b1; sample_data = 32'h607; rst = 1'b1;
        step();
        sample_valid = 1'b0; rst = 1'b0;
        check("t6_rst_status", {wr_data_en, busy, triggered, done, overflow}, 256'd0);
        check("t6_rst_words_written", 256'(words_written), 256'd0);
        check("t6_rst_wr_data", wr_data, 256'd0);
        check_q_empty("t6_no_strobe_after_rst");

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

`default_nettype wire
